// File: rtl/ahb_ui_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module      : ahb_ui_traffic_gen
// Description : Drives write/read bursts onto an AHB master user interface
//               and checks read-back data against the beat index.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_ui_traffic_gen #(
    parameter int unsigned   DATA_WDT  = 32,
    parameter int unsigned   BEAT_WDT  = 32,
    parameter logic [31:0]   LFSR_SEED = 32'hACE1_0001,
    parameter int unsigned   TIMEOUT   = 1024
) (
    input  logic                i_hclk,
    input  logic                i_hreset_n,
    input  logic                i_start,
    input  logic [1:0]          i_mode,
    input  logic [31:0]         i_base_addr,
    input  logic [BEAT_WDT-1:0] i_num_beats,
    input  logic [2:0]          i_size,
    input  logic                i_gap_en,
    input  logic                i_next,
    output logic [DATA_WDT-1:0] o_data,
    output logic                o_dav,
    output logic [31:0]         o_addr,
    output logic [2:0]          o_size,
    output logic                o_wr,
    output logic                o_rd,
    output logic [BEAT_WDT-1:0] o_min_len,
    output logic                o_cont,
    input  logic [DATA_WDT-1:0] i_rd_data,
    input  logic                i_rd_dav,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic [15:0]         o_err_cnt,
    output logic [BEAT_WDT-1:0] o_beat_cnt
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_RUN   = 3'd1;
    localparam logic [2:0] S_RD_RUN   = 3'd2;
    localparam logic [2:0] S_RD_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    // Leaving the drain on this count makes o_done land TIMEOUT cycles after entry.
    localparam logic [31:0] DRAIN_LAST = 32'(TIMEOUT - 2);

    logic [2:0]          state;
    logic [1:0]          mode_q;
    logic [BEAT_WDT-1:0] num_beats_q;
    logic                gap_en_q;
    logic [31:0]         lfsr;
    logic [31:0]         lfsr_next;
    logic [BEAT_WDT-1:0] rd_idx;
    logic [31:0]         drain_timer;
    logic [BEAT_WDT-1:0] accepted;
    logic                last_beat;
    logic                gap_now;
    logic                rd_check;

    assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0000_0000);
    assign accepted  = o_beat_cnt + BEAT_WDT'(o_dav);
    assign last_beat = (accepted == num_beats_q);
    assign gap_now   = gap_en_q && !lfsr[0];
    assign rd_check  = i_rd_dav && ((state == S_RD_RUN) || (state == S_RD_DRAIN));
    assign o_busy    = (state != S_IDLE);

    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            state       <= S_IDLE;
            mode_q      <= 2'b00;
            num_beats_q <= '0;
            gap_en_q    <= 1'b0;
            lfsr        <= LFSR_SEED;
            rd_idx      <= '0;
            drain_timer <= '0;
            o_data      <= '0;
            o_dav       <= 1'b0;
            o_addr      <= '0;
            o_size      <= '0;
            o_wr        <= 1'b0;
            o_rd        <= 1'b0;
            o_min_len   <= '0;
            o_cont      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_err_cnt   <= '0;
            o_beat_cnt  <= '0;
        end else begin
            o_done <= (state == S_DONE);

            if (i_next && (state != S_IDLE)) begin
                lfsr <= lfsr_next;
            end

            if (rd_check) begin
                rd_idx <= rd_idx + 1'b1;
                if (i_rd_data != DATA_WDT'(rd_idx)) begin
                    o_err <= 1'b1;
                    if (o_err_cnt != 16'hFFFF) begin
                        o_err_cnt <= o_err_cnt + 16'd1;
                    end
                end
            end

            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        mode_q      <= i_mode;
                        num_beats_q <= i_num_beats;
                        gap_en_q    <= i_gap_en;
                        o_addr      <= i_base_addr;
                        o_size      <= i_size;
                        o_min_len   <= i_num_beats;
                        o_beat_cnt  <= '0;
                        o_err       <= 1'b0;
                        o_err_cnt   <= '0;
                        rd_idx      <= '0;
                        o_data      <= '0;
                        o_cont      <= 1'b0;
                        if (i_num_beats == '0) begin
                            state <= S_DONE;
                        end else if (i_mode == 2'b01) begin
                            state <= S_RD_RUN;
                            o_rd  <= 1'b1;
                            o_dav <= 1'b1;
                        end else begin
                            state <= S_WR_RUN;
                            o_wr  <= 1'b1;
                            o_dav <= 1'b1;
                        end
                    end
                end

                S_WR_RUN, S_RD_RUN: begin
                    if (i_next) begin
                        if (!(o_wr || o_rd)) begin
                            // Read phase following a write phase: present its first request.
                            o_rd       <= 1'b1;
                            o_dav      <= 1'b1;
                            o_cont     <= 1'b0;
                            o_data     <= '0;
                            o_beat_cnt <= '0;
                        end else begin
                            o_beat_cnt <= accepted;
                            if (last_beat) begin
                                o_wr        <= 1'b0;
                                o_rd        <= 1'b0;
                                o_dav       <= 1'b0;
                                o_cont      <= 1'b0;
                                drain_timer <= '0;
                                if (state == S_RD_RUN) begin
                                    state <= S_RD_DRAIN;
                                end else if (mode_q == 2'b10) begin
                                    state <= S_RD_RUN;
                                end else begin
                                    state <= S_DONE;
                                end
                            end else begin
                                o_cont <= 1'b1;
                                if (gap_now) begin
                                    o_dav <= 1'b0;
                                end else begin
                                    o_dav <= 1'b1;
                                    if (o_wr) begin
                                        o_data <= DATA_WDT'(accepted);
                                    end
                                end
                            end
                        end
                    end
                end

                S_RD_DRAIN: begin
                    if (rd_idx >= num_beats_q) begin
                        state <= S_DONE;
                    end else if (drain_timer == DRAIN_LAST) begin
                        o_err <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        drain_timer <= drain_timer + 32'd1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_ui_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_ui_traffic_gen
// Description : Self-checking bench for ahb_ui_traffic_gen with a loopback slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_ui_traffic_gen;

    localparam int DW = 32;
    localparam int BW = 32;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start;
    logic [1:0]    i_mode;
    logic [31:0]   i_base_addr;
    logic [BW-1:0] i_num_beats;
    logic [2:0]    i_size;
    logic          i_gap_en;
    logic          i_next;
    logic [DW-1:0] o_data;
    logic          o_dav;
    logic [31:0]   o_addr;
    logic [2:0]    o_size;
    logic          o_wr;
    logic          o_rd;
    logic [BW-1:0] o_min_len;
    logic          o_cont;
    logic [DW-1:0] i_rd_data;
    logic          i_rd_dav;
    logic          o_busy;
    logic          o_done;
    logic          o_err;
    logic [15:0]   o_err_cnt;
    logic [BW-1:0] o_beat_cnt;

    always #5 clk = ~clk;

    ahb_ui_traffic_gen #(
        .DATA_WDT (DW),
        .BEAT_WDT (BW),
        .TIMEOUT  (TO)
    ) dut (
        .i_hclk      (clk),
        .i_hreset_n  (rst_n),
        .i_start     (i_start),
        .i_mode      (i_mode),
        .i_base_addr (i_base_addr),
        .i_num_beats (i_num_beats),
        .i_size      (i_size),
        .i_gap_en    (i_gap_en),
        .i_next      (i_next),
        .o_data      (o_data),
        .o_dav       (o_dav),
        .o_addr      (o_addr),
        .o_size      (o_size),
        .o_wr        (o_wr),
        .o_rd        (o_rd),
        .o_min_len   (o_min_len),
        .o_cont      (o_cont),
        .i_rd_data   (i_rd_data),
        .i_rd_dav    (i_rd_dav),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_err_cnt   (o_err_cnt),
        .o_beat_cnt  (o_beat_cnt)
    );

    typedef struct {
        logic [1:0]  mode;
        int          nb;
        bit          gap;
        int          next_pct;
        logic [31:0] corrupt;
        bit          no_ret;
        int          exp_wr;
        int          exp_rd;
        bit          exp_err;
        int          exp_ecnt;
    } vec_t;

    vec_t vecs[6];

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_wq[$];
    int            ret_q[$];
    int            wr_acc, rd_acc, pres_cnt, lb_idx;
    bit            any_wrrd;
    bit            ret_en;
    logic [31:0]   corrupt_mask;
    int            next_pct;
    logic [31:0]   cur_addr;
    logic [2:0]    cur_size;
    int            cur_nb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] mode, input int nb, input bit gap, input int pct,
                                input logic [31:0] corrupt, input bit no_ret, input int ewr,
                                input int erd, input bit eerr, input int ecnt);
        vec_t v;
        v.mode = mode; v.nb = nb; v.gap = gap; v.next_pct = pct; v.corrupt = corrupt;
        v.no_ret = no_ret; v.exp_wr = ewr; v.exp_rd = erd; v.exp_err = eerr; v.exp_ecnt = ecnt;
        return v;
    endfunction

    // UI strobe from the master side
    always @(posedge clk) begin
        #1;
        i_next = (int'($urandom_range(99)) < next_pct);
    end

    // Loopback slave: returns the request index, optionally corrupted
    always @(posedge clk) begin
        #1;
        if (ret_q.size() != 0) begin
            lb_idx    = ret_q.pop_front();
            i_rd_dav  = 1'b1;
            i_rd_data = (lb_idx < 32 && corrupt_mask[lb_idx]) ? 32'hDEAD : 32'(lb_idx);
        end else begin
            i_rd_dav  = 1'b0;
            i_rd_data = '0;
        end
    end

    // Monitor / scoreboard: a beat is taken when i_next is high mid-cycle
    always @(negedge clk) begin
        if (o_wr || o_rd) any_wrrd = 1'b1;
        if (!(o_wr || o_rd)) begin
            pres_cnt = 0;
        end else if (i_next) begin
            check("ui_cont", 64'(o_cont), 64'(pres_cnt != 0));
            pres_cnt++;
            if (o_dav) begin
                check("ui_addr", 64'(o_addr), 64'(cur_addr));
                check("ui_size_len", {29'd0, o_size, o_min_len}, {29'd0, cur_size, 32'(cur_nb)});
                if (o_wr) begin
                    wr_acc++;
                    if (exp_wq.size() == 0) check("wr_extra_beat", 64'd1, 64'd0);
                    else check("wr_data", 64'(o_data), 64'(exp_wq.pop_front()));
                end else begin
                    if (ret_en) ret_q.push_back(rd_acc);
                    rd_acc++;
                end
            end
        end
    end

    task automatic pulse_start(input logic [1:0] mode, input int nb, input bit gap);
        @(posedge clk); #1;
        i_start     = 1'b1;
        i_mode      = mode;
        i_num_beats = BW'(nb);
        i_gap_en    = gap;
        i_base_addr = cur_addr;
        i_size      = cur_size;
        @(posedge clk); #1;
        i_start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk); #2;
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
    endtask

    task automatic setup_run(input vec_t v, input logic [31:0] addr);
        exp_wq.delete();
        ret_q.delete();
        wr_acc = 0; rd_acc = 0; any_wrrd = 1'b0;
        next_pct = v.next_pct; corrupt_mask = v.corrupt; ret_en = !v.no_ret;
        cur_addr = addr; cur_size = 3'd2; cur_nb = v.nb;
        if (v.mode != 2'b01) begin
            for (int j = 0; j < v.nb; j++) exp_wq.push_back(DW'(j));
        end
    endtask

    task automatic run_vec(input vec_t v, input logic [31:0] addr);
        setup_run(v, addr);
        pulse_start(v.mode, v.nb, v.gap);
        wait_done(3000);
        check("wr_count", 64'(wr_acc), 64'(v.exp_wr));
        check("rd_count", 64'(rd_acc), 64'(v.exp_rd));
        check("err_flag", 64'(o_err), 64'(v.exp_err));
        check("err_cnt", 64'(o_err_cnt), 64'(v.exp_ecnt));
        check("wr_queue_empty", 64'(exp_wq.size()), 64'd0);
        check("beat_cnt", 64'(o_beat_cnt), 64'(v.nb));
        repeat (2) @(posedge clk);
    endtask

    initial begin
        bit seen_rd;
        int k;
        rst_n = 1'b0; i_start = 1'b0; i_mode = '0; i_base_addr = '0; i_num_beats = '0;
        i_size = '0; i_gap_en = 1'b0; i_next = 1'b0; i_rd_data = '0; i_rd_dav = 1'b0;
        ret_en = 1'b1; corrupt_mask = '0; next_pct = 100;
        wr_acc = 0; rd_acc = 0; pres_cnt = 0; any_wrrd = 1'b0;
        cur_addr = '0; cur_size = '0; cur_nb = 0;

        vecs[0] = mk(2'b00,  4, 1'b0, 100, 32'h0,          1'b0,  4,  0, 1'b0, 0);
        vecs[1] = mk(2'b10, 20, 1'b1,  70, 32'h0,          1'b0, 20, 20, 1'b0, 0);
        vecs[2] = mk(2'b01,  6, 1'b0, 100, 32'h4,          1'b0,  0,  6, 1'b1, 1);
        vecs[3] = mk(2'b11,  3, 1'b1,  50, 32'h0,          1'b0,  3,  0, 1'b0, 0);
        vecs[4] = mk(2'b01,  5, 1'b1,  80, 32'h12,         1'b0,  0,  5, 1'b1, 2);
        vecs[5] = mk(2'b10,  2, 1'b0, 100, 32'h0,          1'b1,  2,  2, 1'b1, 0);

        repeat (3) @(posedge clk); #2;
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_ctrl", {58'd0, o_wr, o_rd, o_dav, o_done, o_cont, o_err}, 64'd0);
        check("rst_counts", {o_err_cnt, o_beat_cnt}, 64'd0);
        check("rst_data_addr", {o_data, o_addr}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], 32'h1000_0000 + 32'(i * 32'h100));

        // Zero-length burst: done two cycles after the start pulse, no UI activity
        setup_run(mk(2'b10, 0, 1'b0, 100, 32'h0, 1'b0, 0, 0, 1'b0, 0), 32'h2000_0000);
        @(posedge clk); #1;
        i_start = 1'b1; i_mode = 2'b10; i_num_beats = '0; i_base_addr = cur_addr;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("zero_done_early", {62'd0, o_done, o_busy}, 64'd1);
        @(posedge clk); #1;
        check("zero_done_pulse", {62'd0, o_done, o_busy}, 64'd2);
        @(posedge clk); #1;
        check("zero_done_once", 64'(o_done), 64'd0);
        check("zero_no_wr_rd", 64'(any_wrrd), 64'd0);

        // Read timeout latency measured from the drain entry
        setup_run(mk(2'b01, 3, 1'b0, 100, 32'h0, 1'b1, 0, 3, 1'b1, 0), 32'h3000_0000);
        pulse_start(2'b01, 3, 1'b0);
        seen_rd = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (o_rd) seen_rd = 1'b1;
            else if (seen_rd) break;
        end
        check("drain_entered", 64'(seen_rd && !o_rd), 64'd1);
        k = 0;
        for (int c = 0; c < 4 * TO; c++) begin
            @(posedge clk); #1;
            k++;
            if (o_done) break;
        end
        check("timeout_latency", 64'(k), 64'(TO));
        check("timeout_err", {47'd0, o_err, o_err_cnt}, {47'd1, 16'd0});

        // Start pulse while busy must not disturb the running burst
        setup_run(mk(2'b00, 8, 1'b0, 100, 32'h0, 1'b0, 8, 0, 1'b0, 0), 32'h4000_0000);
        pulse_start(2'b00, 8, 1'b0);
        @(posedge clk); #1;
        i_start = 1'b1; i_mode = 2'b01; i_num_beats = BW'(2);
        @(posedge clk); #1;
        i_start = 1'b0; i_num_beats = BW'(8);
        wait_done(200);
        check("busy_start_wr", 64'(wr_acc), 64'd8);
        check("busy_start_rd", 64'(rd_acc), 64'd0);
        repeat (2) @(posedge clk);

        // Asynchronous reset mid-write, no resume, clean restart at beat 0
        setup_run(mk(2'b00, 10, 1'b0, 100, 32'h0, 1'b0, 10, 0, 1'b0, 0), 32'h5000_0000);
        pulse_start(2'b00, 10, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_ctrl", {59'd0, o_busy, o_wr, o_rd, o_dav, o_cont}, 64'd0);
        check("midrst_data_cnt", {o_data, o_beat_cnt}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        check("no_resume", {61'd0, o_busy, o_wr, o_dav}, 64'd0);
        run_vec(mk(2'b00, 5, 1'b0, 100, 32'h0, 1'b0, 5, 0, 1'b0, 0), 32'h6000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_ui_traffic_gen.md
AHB_UI_TRAFFIC_GEN -- requirements
Module: ahb_ui_traffic_gen

Interface
REQ-001 Parameter DATA_WDT, default 32, sets the data width of the user interface.
REQ-002 Parameter BEAT_WDT, default 32, sets the beat-count width.
REQ-003 Parameter LFSR_SEED, default 32'hACE1_0001, is the gap LFSR seed and SHALL be nonzero.
REQ-004 Parameter TIMEOUT, default 1024, is the read-drain timeout in cycles.
REQ-005 i_hclk  in  1  single clock; all logic on its rising edge.
REQ-006 i_hreset_n  in  1  asynchronous active-low reset.
REQ-007 i_start  in  1  one-cycle start pulse.
REQ-008 i_mode  in  2  00 write, 01 read, 10 write-then-read, 11 reserved (treated as 00).
REQ-009 i_base_addr  in  32  burst base address.
REQ-010 i_num_beats  in  BEAT_WDT  beats per phase.
REQ-011 i_size  in  3  transfer size, hsize encoding.
REQ-012 i_gap_en  in  1  enables pseudo-random idle beats.
REQ-013 i_next  in  1  master UI-advance strobe; UI outputs change only when it is 1.
REQ-014 o_data  out  DATA_WDT  write data; o_dav  out  1  write data valid.
REQ-015 o_addr  out  32, o_size  out  3, o_wr  out  1, o_rd  out  1, o_min_len  out  BEAT_WDT, o_cont  out  1: master UI controls.
REQ-016 i_rd_data  in  DATA_WDT, i_rd_dav  in  1: read return from master.
REQ-017 o_busy  out  1, o_done  out  1 (pulse), o_err  out  1 (sticky), o_err_cnt  out  16, o_beat_cnt  out  BEAT_WDT.

Function
REQ-018 FSM states: IDLE, WR_RUN, RD_RUN, RD_DRAIN, DONE.
REQ-019 IDLE + i_start: latch mode/addr/num_beats/size/gap_en, clear beat and error counters, go to WR_RUN (mode 00/10/11) or RD_RUN (01); i_start outside IDLE is ignored.
REQ-020 i_num_beats=0 at start: go directly to DONE; no o_wr/o_rd assertion.
REQ-021 WR_RUN: o_wr=1, o_addr=latched base, o_min_len=latched num_beats, o_size=latched size; on each i_next=1 the next beat is presented.
REQ-022 Beat k write data is k zero-extended or truncated to DATA_WDT; k counts only beats presented with o_dav=1.
REQ-023 Gap: when gap_en=1 and LFSR bit0=0 at an i_next=1 edge, present o_dav=0 with o_data held and k unchanged; the LFSR (32-bit Galois, taps 32,22,2,1) advances on every i_next=1 edge while busy.
REQ-024 o_cont=0 on the first presented beat of a phase, 1 on every later beat of that phase.
REQ-025 After num_beats valid beats are accepted, at the next i_next=1 drive o_wr=0, o_dav=0, o_cont=0; then go to RD_RUN (mode 10) or DONE.
REQ-026 RD_RUN: o_rd=1, o_dav=1 per requested beat, same address/length/cont rules; after num_beats requests, deassert o_rd at the next i_next=1 and go to RD_DRAIN.
REQ-027 Read check: each i_rd_dav=1 compares i_rd_data with the expected index j (0..num_beats-1, in order); on mismatch set o_err and increment o_err_cnt, saturating at 16'hFFFF.
REQ-028 RD_DRAIN: go to DONE once j reaches num_beats; if TIMEOUT cycles elapse first, set o_err and go to DONE.
REQ-029 i_rd_dav outside RD_RUN/RD_DRAIN is ignored.
REQ-030 DONE: o_done=1 for exactly one cycle, then IDLE; o_busy=1 in every state except IDLE.
REQ-031 o_beat_cnt reports valid write or read-request beats accepted in the current phase.

Reset
REQ-032 With i_hreset_n=0, immediately and also mid-operation: state IDLE, all outputs 0, LFSR=LFSR_SEED, counters and o_err cleared.
REQ-033 No transfer resumes after reset release without a new i_start.

Verification
REQ-034 Mode 00, num_beats=4, gap_en=0, i_next always 1 -> o_dav=1 with o_data 0,1,2,3, o_cont 0,1,1,1, then o_wr=0 and o_done a few cycles later.
REQ-035 Mode 10, num_beats=20, gap_en=1, loopback slave -> exactly 20 valid writes, 20 reads returned, o_err=0, o_err_cnt=0.
REQ-036 Read with returned beat 2 corrupted to 32'hDEAD -> o_err=1, o_err_cnt=1.
REQ-037 Read with no i_rd_dav returned -> o_done TIMEOUT cycles after drain entry, o_err=1.
REQ-038 num_beats=0 -> o_done two cycles after i_start; o_wr and o_rd never asserted.
REQ-039 Reset asserted mid-write, then released -> all outputs 0; a fresh i_start restarts data at 0.
